// File: rtl/multiplier_seq_if.sv
// multiplier_seq_if: start/operand request and busy/done/product response bundle for multiplier_seq
interface multiplier_seq_if #(parameter int width = 8);
  logic                 start;
  logic [width-1:0]     a;
  logic [width-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*width-1:0]   product;
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/multiplier_seq.sv
// multiplier_seq: shift-and-add unsigned multiplier, IDLE/RUN/DONE FSM; define MULTIPLIER_SEQ_EARLY_TERM_EN to stop once the multiplier runs out of set bits
module multiplier_seq #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  multiplier_seq_if.slave  bus
);
  localparam int CW = $clog2(width) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               r_state, w_next;
  logic [2*width-1:0]   r_mcand, r_acc, r_product, w_acc_next;
  logic [width-1:0]     r_mplier, w_mplier_next;
  logic [CW-1:0]        r_count;
  logic                 w_last;
  assign w_acc_next    = r_mplier[0] ? r_acc + r_mcand : r_acc;
  assign w_mplier_next = {1'b0, r_mplier[width-1:1]};
`ifdef MULTIPLIER_SEQ_EARLY_TERM_EN
  assign w_last = (r_count == CW'(width - 1)) || (w_mplier_next == '0);
`else
  assign w_last = r_count == CW'(width - 1);
`endif
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (bus.start ? RUN : IDLE) :
             r_state == RUN  ? (w_last ? DONE : RUN) : IDLE;
  end
  // product only moves on DONE entry, so it keeps the previous result through IDLE and RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else if (r_state == IDLE && bus.start) begin
      r_mcand   <= {{width{1'b0}}, bus.a};
      r_mplier  <= bus.b;
      r_acc     <= '0;
      r_count   <= '0;
    end else if (r_state == RUN) begin
      r_acc     <= w_acc_next;
      r_mcand   <= r_mcand << 1;
      r_mplier  <= w_mplier_next;
      r_count   <= r_count + 1'b1;
      if (w_last) r_product <= w_acc_next;
    end
  end
  assign bus.busy    = r_state == RUN;
  assign bus.done    = r_state == DONE;
  assign bus.product = r_product;
endmodule

// File: tb/tb_multiplier_seq.sv
// tb_multiplier_seq: directed-vector bench for multiplier_seq at width 8, latency expectations follow MULTIPLIER_SEQ_EARLY_TERM_EN
module tb_multiplier_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  multiplier_seq_if #(.width(8)) bus ();
  multiplier_seq #(.width(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int exp_cycles(input logic [7:0] b);
    int n;
`ifdef MULTIPLIER_SEQ_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
`else
    n = 8;
`endif
    return n;
  endfunction
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int n = 0;
    bus.start = 1'b1; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, n, exp_cycles(b));
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_product"}, bus.product, exp);
    @(negedge clk);
    check({tag, "_idle"}, {bus.busy, bus.done}, 0);
    check({tag, "_held"}, bus.product, exp);
  endtask
  task automatic wait_done(input string tag, output int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 100);
    if (!bus.done) check({tag, "_timeout"}, 0, 1);
    t = cyc;
  endtask
  initial begin
    int n, t0, t1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_product", bus.product, 0);
    reset = 1'b0;
    run_op("m13x11", 8'd13, 8'd11, 16'd143);
    run_op("m255x255", 8'd255, 8'd255, 16'hFE01);
    run_op("m128x1", 8'h80, 8'h01, 16'd128);
    run_op("m77x0", 8'd77, 8'd0, 16'd0);
    // second request lands mid-RUN and must be dropped
    bus.start = 1'b1; bus.a = 8'd5; bus.b = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (n == 3) begin bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd9; end
      else bus.start = 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("ign_cycles", n, exp_cycles(8'd7));
    check("ign_done", bus.done, 1);
    check("ign_product", bus.product, 35);
    @(negedge clk);
    check("ign_idle", {bus.busy, bus.done}, 0);
    @(negedge clk);
    check("ign_no_restart", bus.busy, 0);
    // reset in RUN cycle 4 must wipe product without a partial result
    bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_busy_before", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_done", bus.done, 0);
    check("rst_mid_product", bus.product, 0);
    run_op("m3x4", 8'd3, 8'd4, 16'd12);
    // start held high: back-to-back operations every width+2 cycles
    bus.start = 1'b1; bus.a = 8'd2; bus.b = 8'd3;
    wait_done("hold1", t0);
    check("hold1_product", bus.product, 6);
    wait_done("hold2", t1);
    check("hold2_period", t1 - t0, exp_cycles(8'd3) + 2);
    check("hold2_product", bus.product, 6);
    wait_done("hold3", t0);
    check("hold3_period", t0 - t1, exp_cycles(8'd3) + 2);
    check("hold3_product", bus.product, 6);
    bus.a = 8'd0;
    wait_done("hold4", t1);
    check("hold4_period", t1 - t0, exp_cycles(8'd3) + 2);
    check("hold4_product", bus.product, 0);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_stop_busy", bus.busy, 0);
    check("hold_stop_product", bus.product, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multiplier_seq.md
MULTIPLIER_SEQ -- requirements
Module: multiplier_seq

Interface
REQ-001 The block SHALL have parameter: width, default 8, operand width in bits (legal values >= 2).
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port: a  input  width  unsigned multiplicand; captured on the accepting edge.
REQ-006 The block SHALL have port: b  input  width  unsigned multiplier; captured on the accepting edge.
REQ-007 The block SHALL have port: busy  output  1  high while state is RUN.
REQ-008 The block SHALL have port: done  output  1  high for exactly one cycle while state is DONE.
REQ-009 The block SHALL have port: product  output  2*width  result register; valid while done is high and held until the next accepted start.

Function
REQ-010 The block SHALL implement the states IDLE, RUN and DONE, with the state held in a registered FSM.
REQ-011 The block SHALL contain three internal registers: mcand (2*width bits, left-shifting), mplier (width bits, right shift with zero fill into the MSB), and acc (2*width bits).
REQ-012 In IDLE with start=1, the block SHALL on that edge load mcand={0,a}, mplier=b, acc=0 and count=0, and enter RUN.
REQ-013 On each RUN edge, if mplier[0]=1 the block SHALL set acc <= acc + mcand (modulo 2^(2*width), no overflow possible).
REQ-014 On each RUN edge, the block SHALL set mcand <= mcand<<1, mplier <= {1'b0, mplier[width-1:1]} and count <= count+1.
REQ-015 The block SHALL size count at clog2(width)+1 bits.
REQ-016 The block SHALL leave RUN for DONE on the edge that performs iteration width (count==width-1 before the edge).
REQ-017 On the same edge as REQ-016, the block SHALL load product with the final acc value, including that edge's addition.
REQ-018 Latency: with start sampled at edge N, done SHALL be high in the cycle after edge N+width; busy SHALL be high for width cycles.
REQ-019 The block SHALL leave DONE for IDLE unconditionally after one cycle; start is ignored during that DONE cycle.
REQ-020 The block SHALL ignore start while in RUN; a, b, mcand, mplier and acc are unaffected by input changes during RUN.
REQ-021 The block SHALL change product only on DONE entry; product is stable in IDLE and during RUN, showing the previous result.
REQ-022 When start is held high continuously, the block SHALL accept a new operation in the first IDLE cycle after each DONE, giving a period of width+2 cycles.

Reset
REQ-023 When reset=1 at a posedge, the block SHALL force state=IDLE, busy=0, done=0, product=0, acc=0, mcand=0, mplier=0 and count=0.
REQ-024 Reset SHALL take priority over start and over all FSM transitions, including mid-RUN; no partial result reaches product.
REQ-025 After reset deasserts, the block SHALL accept start on the first following edge.

Configuration
REQ-026 The block SHALL support the macro MULTIPLIER_SEQ_EARLY_TERM_EN.
REQ-027 When MULTIPLIER_SEQ_EARLY_TERM_EN is defined, the block SHALL also leave RUN for DONE on any RUN edge whose post-shift mplier value is zero, loading product as in REQ-017.
REQ-028 When MULTIPLIER_SEQ_EARLY_TERM_EN is defined, the number of RUN cycles SHALL be max(1, position of the highest set bit of b plus 1).
REQ-029 When MULTIPLIER_SEQ_EARLY_TERM_EN is undefined, the block SHALL always perform exactly width RUN cycles regardless of operand values.
REQ-030 Results SHALL be identical with and without MULTIPLIER_SEQ_EARLY_TERM_EN; only latency differs.

Verification
REQ-031 The bench SHALL cover: width=8, a=13, b=11, start 1 cycle -> busy 8 cycles, done 1 cycle, product=143, then IDLE.
REQ-032 The bench SHALL cover: a=255, b=255 -> product=65025 (0xFE01), with no wrap of acc.
REQ-033 The bench SHALL cover: a=0x80, b=0x01 -> product=128; with EARLY_TERM_EN, done after 1 RUN cycle; without it, after 8 RUN cycles.
REQ-034 The bench SHALL cover: a=5, b=7 started, then start pulsed with a=9, b=9 at RUN cycle 3 -> product=35, and the second request is ignored.
REQ-035 The bench SHALL cover: reset asserted at RUN cycle 4 of a=200, b=100 -> next cycle IDLE with busy=0, done=0, product=0; a fresh start with a=3, b=4 -> product=12.
REQ-036 The bench SHALL cover: start held high with a=2, b=3 -> done pulses every 10 cycles (width+2), product=6 each time, and a=0 gives product=0.
